// File: rtl/ps2_rx_frame_if.sv
// PS/2 receiver bundle: raw PS/2 lines in, 16-bit PIO word out.
// The master side drives the PS/2 lines (device/bench); the slave side is the receiver.
interface ps2_rx_frame_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] out_port;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  out_port
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output out_port
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver feeding a 16-bit edge-capturing PIO.
// Optional E0/F0 prefix folding is enabled by defining PS2_PREFIX_DECODE_EN.
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic           clk,
  input  logic           reset_n,
  ps2_rx_frame_if.slave  bus
);

  localparam int              TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TOUT_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // bit 0 = ps2_clk, bit 1 = ps2_data
  logic [1:0]            meta_reg;
  logic [1:0]            sync_reg;
  logic [FILTER_LEN-1:0] filt_sh_reg;
  logic                  filt_reg;
  logic                  filt_prev_reg;
  logic                  fall;
  logic                  data_sync;

  state_t                state_reg;
  logic [3:0]            bit_cnt_reg;
  logic [TW-1:0]         tout_reg;
  logic                  tout_flag_reg;
  logic [9:0]            shift_reg;

  logic [7:0]            byte_reg;
  logic                  perr_reg;
  logic                  ferr_reg;
  logic                  terr_reg;
  logic                  busy_reg;
  logic                  strobe_reg;
  logic                  ext_bit;
  logic                  brk_bit;

  logic                  perr_w;
  logic                  ferr_w;
  logic                  good_w;

  // ------------------------------------------------------------------
  // Input conditioning
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_reg      <= 2'b11;
      sync_reg      <= 2'b11;
      filt_sh_reg   <= '1;
      filt_reg      <= 1'b1;
      filt_prev_reg <= 1'b1;
    end else begin
      meta_reg      <= {bus.ps2_data, bus.ps2_clk};
      sync_reg      <= meta_reg;
      filt_sh_reg   <= {filt_sh_reg[FILTER_LEN-2:0], sync_reg[0]};
      // Hysteresis: only a full window of agreeing samples moves the filtered clock
      if (filt_sh_reg == '0) begin
        filt_reg <= 1'b0;
      end else if (&filt_sh_reg) begin
        filt_reg <= 1'b1;
      end
      filt_prev_reg <= filt_reg;
    end
  end

  assign fall      = filt_prev_reg & ~filt_reg;
  assign data_sync = sync_reg[1];

  // Frame checks on the completed shift register (data[7:0], parity, stop)
  assign perr_w = ~(^shift_reg[8:0]);
  assign ferr_w = ~shift_reg[9];
  assign good_w = ~perr_w & ~ferr_w & ~tout_flag_reg;

`ifdef PS2_PREFIX_DECODE_EN
  logic ext_reg;
  logic brk_reg;
  logic ext_out_reg;
  logic brk_out_reg;
  assign ext_bit = ext_out_reg;
  assign brk_bit = brk_out_reg;
`else
  assign ext_bit = 1'b0;
  assign brk_bit = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Frame FSM with registered PIO fields
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= 4'd0;
      tout_reg      <= '0;
      tout_flag_reg <= 1'b0;
      shift_reg     <= 10'd0;
      byte_reg      <= 8'd0;
      perr_reg      <= 1'b0;
      ferr_reg      <= 1'b0;
      terr_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      strobe_reg    <= 1'b0;
`ifdef PS2_PREFIX_DECODE_EN
      ext_reg       <= 1'b0;
      brk_reg       <= 1'b0;
      ext_out_reg   <= 1'b0;
      brk_out_reg   <= 1'b0;
`endif
    end else begin
      strobe_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (fall && !data_sync) begin
            bit_cnt_reg   <= 4'd0;
            tout_reg      <= '0;
            tout_flag_reg <= 1'b0;
            state_reg     <= SHIFT;
            busy_reg      <= 1'b1;
          end
        end

        SHIFT: begin
          if (fall) begin
            shift_reg   <= {data_sync, shift_reg[9:1]};
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
            tout_reg    <= '0;
            if (bit_cnt_reg == 4'd9) begin
              state_reg <= DONE;
            end
          end else if (tout_reg == TOUT_MAX) begin
            tout_flag_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            tout_reg <= tout_reg + 1'b1;
          end
        end

        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
`ifdef PS2_PREFIX_DECODE_EN
          // Good prefix bytes are absorbed into flags and produce no strobe
          if (good_w && shift_reg[7:0] == 8'hE0) begin
            ext_reg <= 1'b1;
          end else if (good_w && shift_reg[7:0] == 8'hF0) begin
            brk_reg <= 1'b1;
          end else begin
            strobe_reg  <= 1'b1;
            byte_reg    <= tout_flag_reg ? 8'h00 : shift_reg[7:0];
            perr_reg    <= perr_w & ~tout_flag_reg;
            ferr_reg    <= ferr_w & ~tout_flag_reg;
            terr_reg    <= tout_flag_reg;
            ext_out_reg <= good_w & ext_reg;
            brk_out_reg <= good_w & brk_reg;
            ext_reg     <= 1'b0;
            brk_reg     <= 1'b0;
          end
`else
          strobe_reg <= 1'b1;
          byte_reg   <= tout_flag_reg ? 8'h00 : shift_reg[7:0];
          perr_reg   <= perr_w & ~tout_flag_reg;
          ferr_reg   <= ferr_w & ~tout_flag_reg;
          terr_reg   <= tout_flag_reg;
`endif
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_port = {strobe_reg, busy_reg, 1'b0, brk_bit, ext_bit,
                         terr_reg, ferr_reg, perr_reg, byte_reg};

endmodule
